// File: rtl/mac_dot_lanes.sv
// Multi-lane dot-product MAC: LANES products summed per beat, accumulated over a framed vector.
// Optional build macro MAC_SATURATE_EN clamps the presented result instead of truncating it.
module mac_dot_lanes #(
  parameter int WIDTH     = 8,
  parameter int LANES     = 4,
  parameter int MAX_BEATS = 16,
  parameter int SIGNED    = 0,
  parameter int OUT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*WIDTH-1:0]     in_a,
  input  logic [LANES*WIDTH-1:0]     in_b,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_WIDTH-1:0]       out_data,
  output logic [$clog2(MAX_BEATS):0] out_beats,
  output logic                       err_ovf
);

  localparam int ACC_W = 2*WIDTH + $clog2(LANES) + $clog2(MAX_BEATS);
  localparam int CNT_W = $clog2(MAX_BEATS) + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

  logic                   stall;
  logic                   accept;
  logic                   r_valid, r_last;
  logic [LANES*WIDTH-1:0] r_a, r_b;
  logic [ACC_W-1:0]       lane_sum;
  logic                   p_valid, p_last;
  logic [ACC_W-1:0]       psum;
  logic [ACC_W-1:0]       acc, acc_next;
  logic [CNT_W-1:0]       cnt, cnt_next;
  logic                   first;
  logic [OUT_WIDTH-1:0]   final_data;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall & ~reset;
  assign accept   = in_valid & in_ready;

  function automatic logic [ACC_W-1:0] lane_prod(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic signed [2*WIDTH-1:0] sp;
    logic        [2*WIDTH-1:0] up;
    sp = $signed(a) * $signed(b);
    up = a * b;
    if (SIGNED != 0) return ACC_W'(sp);
    else             return ACC_W'(up);
  endfunction

  // Input register: operands are captured on the handshake so the multipliers see a stable beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
    end else if (!stall) begin
      r_valid <= accept;
      r_last  <= accept & in_last;
      if (accept) begin
        r_a <= in_a;
        r_b <= in_b;
      end
    end
  end

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++)
      lane_sum = lane_sum + lane_prod(r_a[i*WIDTH +: WIDTH], r_b[i*WIDTH +: WIDTH]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_valid <= 1'b0;
      p_last  <= 1'b0;
      psum    <= '0;
    end else if (!stall) begin
      p_valid <= r_valid;
      p_last  <= r_valid & r_last;
      psum    <= lane_sum;
    end
  end

  always_comb begin
    acc_next = (first ? '0 : acc) + psum;
    if (first)               cnt_next = CNT_W'(1);
    else if (cnt == MAX_CNT) cnt_next = cnt;
    else                     cnt_next = cnt + CNT_W'(1);
  end

`ifdef MAC_SATURATE_EN
  localparam logic [ACC_W-1:0] S_MAX = ACC_W'((64'sd1 <<< (OUT_WIDTH-1)) - 64'sd1);
  localparam logic [ACC_W-1:0] S_MIN = ~S_MAX;
  localparam logic [ACC_W-1:0] U_MAX = ACC_W'((64'd1 << OUT_WIDTH) - 64'd1);

  always_comb begin
    final_data = acc_next[OUT_WIDTH-1:0];
    if (SIGNED != 0) begin
      if ($signed(acc_next) > $signed(S_MAX))      final_data = S_MAX[OUT_WIDTH-1:0];
      else if ($signed(acc_next) < $signed(S_MIN)) final_data = S_MIN[OUT_WIDTH-1:0];
    end else if (acc_next > U_MAX) begin
      final_data = U_MAX[OUT_WIDTH-1:0];
    end
  end
`else
  always_comb begin
    final_data = acc_next[OUT_WIDTH-1:0];
  end
`endif

  // A new frame result may overwrite a result being handed off in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      cnt       <= '0;
      first     <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_beats <= '0;
      err_ovf   <= 1'b0;
    end else if (!stall) begin
      if (p_valid) begin
        acc   <= acc_next;
        cnt   <= cnt_next;
        first <= p_last;
        if (!first && cnt == MAX_CNT) err_ovf <= 1'b1;
      end
      if (p_valid && p_last) begin
        out_valid <= 1'b1;
        out_data  <= final_data;
        out_beats <= cnt_next;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_dot_lanes.sv
// Directed bench for mac_dot_lanes: unsigned and signed instances share one input stream.
// Expected values follow the MAC_SATURATE_EN build macro when it is defined.
`timescale 1ns/1ps
module tb_mac_dot_lanes;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_a, in_b;
  logic        in_last;
  logic        out_ready;

  logic        in_ready,  out_valid,  err_ovf;
  logic [15:0] out_data;
  logic [4:0]  out_beats;
  logic        in_ready_s, out_valid_s, err_ovf_s;
  logic [15:0] out_data_s;
  logic [4:0]  out_beats_s;

  int checks = 0;
  int errors = 0;

  logic [15:0] q_data[$];
  logic [4:0]  q_beats[$];

`ifdef MAC_SATURATE_EN
  localparam logic [15:0] EXP_SGN  = 16'h8000;
  localparam logic [15:0] EXP_WIDE = 16'hFFFF;
`else
  localparam logic [15:0] EXP_SGN  = 16'h0200;
  localparam logic [15:0] EXP_WIDE = 16'hF804;
`endif

  mac_dot_lanes #(.WIDTH(8), .LANES(4), .MAX_BEATS(16), .SIGNED(0), .OUT_WIDTH(16)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_beats(out_beats), .err_ovf(err_ovf)
  );

  mac_dot_lanes #(.WIDTH(8), .LANES(4), .MAX_BEATS(16), .SIGNED(1), .OUT_WIDTH(16)) u_sgn (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
    .out_beats(out_beats_s), .err_ovf(err_ovf_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every output handshake; the transfer completes on the following rising edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_beats.push_back(out_beats);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic last,
                           output int waited);
    logic rdy;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    waited   = 0;
    for (int k = 0; k < 50; k++) begin
      rdy = in_ready;
      @(posedge clk); #1;
      waited++;
      if (rdy) break;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(output int cycles);
    cycles = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      cycles++;
      if (out_valid) break;
    end
  endtask

  task automatic idle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", out_valid); end
    checks++; if (out_data !== 16'd0) begin errors++; $display("[TB] FAIL reset_data: got %0d expected 0", out_data); end
    checks++; if (out_beats !== 5'd0) begin errors++; $display("[TB] FAIL reset_beats: got %0d expected 0", out_beats); end
    checks++; if (err_ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %0b expected 0", err_ovf); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %0b expected 0", in_ready); end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_in_ready: got %0b expected 1", in_ready); end
  endtask

  task automatic test_single();
    int w, c;
    idle();
    send_beat(32'h04030201, 32'h08070605, 1'b1, w);
    wait_out(c);
    checks++; if (c != 2) begin errors++; $display("[TB] FAIL single_latency: got %0d expected 2", c); end
    checks++; if (out_data !== 16'd70) begin errors++; $display("[TB] FAIL single_data: got %0d expected 70", out_data); end
    checks++; if (out_beats !== 5'd1) begin errors++; $display("[TB] FAIL single_beats: got %0d expected 1", out_beats); end
    checks++; if (err_ovf !== 1'b0) begin errors++; $display("[TB] FAIL single_err: got %0b expected 0", err_ovf); end
    checks++; if (out_data_s !== 16'd70) begin errors++; $display("[TB] FAIL single_signed_data: got %0d expected 70", out_data_s); end
  endtask

  task automatic test_back_to_back();
    int w, total;
    idle();
    q_data.delete();
    q_beats.delete();
    total = 0;
    for (int i = 0; i < 3; i++) begin
      send_beat(32'h02020202, 32'h03030303, (i == 2), w);
      total += w;
    end
    for (int i = 0; i < 2; i++) begin
      send_beat(32'h04030201, 32'h01010101, (i == 1), w);
      total += w;
    end
    repeat (6) @(posedge clk);
    #1;
    checks++; if (total != 5) begin errors++; $display("[TB] FAIL b2b_cycles: got %0d expected 5", total); end
    checks++; if (q_data.size() != 2) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 2", q_data.size()); end
    if (q_data.size() >= 2) begin
      checks++; if (q_data[0] !== 16'd72) begin errors++; $display("[TB] FAIL b2b_data0: got %0d expected 72", q_data[0]); end
      checks++; if (q_beats[0] !== 5'd3) begin errors++; $display("[TB] FAIL b2b_beats0: got %0d expected 3", q_beats[0]); end
      checks++; if (q_data[1] !== 16'd20) begin errors++; $display("[TB] FAIL b2b_data1: got %0d expected 20", q_data[1]); end
      checks++; if (q_beats[1] !== 5'd2) begin errors++; $display("[TB] FAIL b2b_beats1: got %0d expected 2", q_beats[1]); end
    end
  endtask

  task automatic test_signed();
    int w, c;
    idle();
    send_beat(32'h80808080, 32'h7F7F7F7F, 1'b1, w);
    wait_out(c);
    checks++; if (out_data_s !== EXP_SGN) begin errors++; $display("[TB] FAIL signed_data: got %h expected %h", out_data_s, EXP_SGN); end
    checks++; if (out_beats_s !== 5'd1) begin errors++; $display("[TB] FAIL signed_beats: got %0d expected 1", out_beats_s); end
    checks++; if (out_data !== 16'd65024) begin errors++; $display("[TB] FAIL signed_unsigned_view: got %0d expected 65024", out_data); end
  endtask

  task automatic test_wide();
    int w, c;
    idle();
    send_beat(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, w);
    wait_out(c);
    checks++; if (out_data !== EXP_WIDE) begin errors++; $display("[TB] FAIL wide_data: got %h expected %h", out_data, EXP_WIDE); end
    checks++; if (out_data_s !== 16'd4) begin errors++; $display("[TB] FAIL wide_signed_data: got %0d expected 4", out_data_s); end
  endtask

  task automatic test_gap();
    int w, c;
    idle();
    send_beat(32'h01010101, 32'h01010101, 1'b0, w);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL gap_no_early_result: got %0b expected 0", out_valid); end
    send_beat(32'h01010101, 32'h01010101, 1'b1, w);
    wait_out(c);
    checks++; if (out_data !== 16'd8) begin errors++; $display("[TB] FAIL gap_data: got %0d expected 8", out_data); end
    checks++; if (out_beats !== 5'd2) begin errors++; $display("[TB] FAIL gap_beats: got %0d expected 2", out_beats); end
  endtask

  task automatic test_stall();
    int w, c;
    idle();
    send_beat(32'h04030201, 32'h08070605, 1'b1, w);
    out_ready = 1'b0;
    wait_out(c);
    checks++; if (c != 2) begin errors++; $display("[TB] FAIL stall_latency: got %0d expected 2", c); end
    in_valid = 1'b1;
    in_a     = 32'h01010101;
    in_b     = 32'h01010101;
    in_last  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_in_ready: got %0b expected 0", in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid: got %0b expected 1", out_valid); end
      checks++; if (out_data !== 16'd70) begin errors++; $display("[TB] FAIL stall_data: got %0d expected 70", out_data); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_release_valid: got %0b expected 0", out_valid); end
    checks++; if (out_data !== 16'd70) begin errors++; $display("[TB] FAIL stall_release_hold: got %0d expected 70", out_data); end
    wait_out(c);
    checks++; if (c != 2) begin errors++; $display("[TB] FAIL stall_resume_latency: got %0d expected 2", c); end
    checks++; if (out_data !== 16'd4) begin errors++; $display("[TB] FAIL stall_resume_data: got %0d expected 4", out_data); end
  endtask

  task automatic test_overflow();
    int w, c, total;
    idle();
    total = 0;
    for (int i = 0; i < 17; i++) begin
      send_beat(32'h01010101, 32'h01010101, (i == 16), w);
      total += w;
    end
    wait_out(c);
    checks++; if (total != 17) begin errors++; $display("[TB] FAIL ovf_cycles: got %0d expected 17", total); end
    checks++; if (out_data !== 16'd68) begin errors++; $display("[TB] FAIL ovf_data: got %0d expected 68", out_data); end
    checks++; if (out_beats !== 5'd16) begin errors++; $display("[TB] FAIL ovf_beats: got %0d expected 16", out_beats); end
    checks++; if (err_ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_err: got %0b expected 1", err_ovf); end
    idle();
    send_beat(32'h01010101, 32'h01010101, 1'b1, w);
    wait_out(c);
    checks++; if (err_ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %0b expected 1", err_ovf); end
    checks++; if (out_beats !== 5'd1) begin errors++; $display("[TB] FAIL ovf_next_beats: got %0d expected 1", out_beats); end
    checks++; if (out_data !== 16'd4) begin errors++; $display("[TB] FAIL ovf_next_data: got %0d expected 4", out_data); end
  endtask

  task automatic test_reset_mid();
    int w, c;
    idle();
    send_beat(32'h02020202, 32'h03030303, 1'b0, w);
    send_beat(32'h02020202, 32'h03030303, 1'b0, w);
    #2;
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_valid: got %0b expected 0", out_valid); end
    checks++; if (out_data !== 16'd0) begin errors++; $display("[TB] FAIL midreset_data: got %0d expected 0", out_data); end
    checks++; if (out_beats !== 5'd0) begin errors++; $display("[TB] FAIL midreset_beats: got %0d expected 0", out_beats); end
    checks++; if (err_ovf !== 1'b0) begin errors++; $display("[TB] FAIL midreset_err: got %0b expected 0", err_ovf); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL midreset_in_ready: got %0b expected 0", in_ready); end
    @(posedge clk); #1;
    reset = 1'b0;
    idle();
    send_beat(32'h04030201, 32'h08070605, 1'b1, w);
    wait_out(c);
    checks++; if (c != 2) begin errors++; $display("[TB] FAIL midreset_latency: got %0d expected 2", c); end
    checks++; if (out_data !== 16'd70) begin errors++; $display("[TB] FAIL midreset_data_clean: got %0d expected 70", out_data); end
    checks++; if (out_beats !== 5'd1) begin errors++; $display("[TB] FAIL midreset_beats_clean: got %0d expected 1", out_beats); end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    $display("[TB] starting mac_dot_lanes bench");
    test_reset();
    test_single();
    test_back_to_back();
    test_signed();
    test_wide();
    test_gap();
    test_stall();
    test_overflow();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
